// File: rtl/proc_core_if.sv
// Memory-port bundle between one proc_core and its port on the shared memory subsystem.
// The core drives requests through the master modport; the memory answers through slave.
interface proc_core_if #(
    parameter int ADDR_W = 16
);
    logic              processor_req;
    logic              processor_resp;
    logic              mem_read_req;
    logic              mem_write_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_write_data;
    logic [15:0]       mem_read_data;

    modport master (
        output processor_req,
        output mem_read_req,
        output mem_write_req,
        output mem_addr,
        output mem_write_data,
        input  processor_resp,
        input  mem_read_data
    );

    modport slave (
        input  processor_req,
        input  mem_read_req,
        input  mem_write_req,
        input  mem_addr,
        input  mem_write_data,
        output processor_resp,
        output mem_read_data
    );
endinterface

// File: rtl/proc_core.sv
// Processing node: fetch/decode/execute FSM, 4-entry register file, ALU and memory front end.
// Define PROC_MUL_EN to build the 3-cycle multiplier for opcode 5; otherwise opcode 5 is illegal.
module proc_core #(
    parameter int ADDR_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    proc_core_if.master     mem,
    output logic            halted,
    output logic            error
);
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDI   = 4'h1,
        OP_ADD   = 4'h2,
        OP_AND   = 4'h3,
        OP_XOR   = 4'h4,
        OP_MUL   = 4'h5,
        OP_LOAD  = 4'h6,
        OP_STORE = 4'h7,
        OP_HALT  = 4'h8
    } op_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] regs [4];

    logic              rd_req;
    logic              wr_req;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              alu_start;
    op_t               alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_done;
    logic [DATA_W-1:0] alu_result;

    op_t               op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [7:0]        imm;

    assign op  = op_t'(ir[15:12]);
    assign rd  = ir[11:10];
    assign rs  = ir[9:8];
    assign imm = ir[7:0];

    assign mem.mem_read_req   = rd_req;
    assign mem.mem_write_req  = wr_req;
    assign mem.processor_req  = rd_req | wr_req;
    assign mem.mem_addr       = addr_q;
    assign mem.mem_write_data = wdata_q;

    // Requests are registered: every path into FETCH either raises the fetch
    // request directly or leaves FETCH to raise it on its first cycle.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state     <= S_FETCH;
            pc        <= '0;
            ir        <= '0;
            for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
            rd_req    <= 1'b0;
            wr_req    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            halted    <= 1'b0;
            error     <= 1'b0;
            alu_start <= 1'b0;
            alu_op    <= OP_NOP;
            alu_a     <= '0;
            alu_b     <= '0;
        end else begin
            alu_start <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!rd_req) begin
                        rd_req <= 1'b1;
                        addr_q <= pc;
                    end else if (mem.processor_resp) begin
                        ir     <= mem.mem_read_data;
                        pc     <= pc + ADDR_W'(1);
                        rd_req <= 1'b0;
                        state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (op)
                        OP_NOP: begin
                            rd_req <= 1'b1;
                            addr_q <= pc;
                            state  <= S_FETCH;
                        end
                        OP_LDI: begin
                            regs[rd] <= {8'h00, imm};
                            rd_req   <= 1'b1;
                            addr_q   <= pc;
                            state    <= S_FETCH;
                        end
`ifdef PROC_MUL_EN
                        OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
`else
                        OP_ADD, OP_AND, OP_XOR: begin
`endif
                            alu_start <= 1'b1;
                            alu_op    <= op;
                            alu_a     <= regs[rd];
                            alu_b     <= regs[rs];
                            state     <= S_EXEC;
                        end
                        OP_LOAD: begin
                            rd_req <= 1'b1;
                            addr_q <= ADDR_W'(imm);
                            state  <= S_MEM;
                        end
                        OP_STORE: begin
                            wr_req  <= 1'b1;
                            addr_q  <= ADDR_W'(imm);
                            wdata_q <= regs[rd];
                            state   <= S_MEM;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            error  <= 1'b1;
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (alu_done) begin
                        regs[rd] <= alu_result;
                        rd_req   <= 1'b1;
                        addr_q   <= pc;
                        state    <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem.processor_resp) begin
                        if (rd_req) regs[rd] <= mem.mem_read_data;
                        rd_req <= 1'b0;
                        wr_req <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef PROC_MUL_EN
    logic [DATA_W-1:0] mul_pp_lo;
    logic [7:0]        mul_pp_hi;
    logic [DATA_W-1:0] mul_sum;
    logic              mul_v1;
    logic              mul_v2;
`endif

    // Single-cycle ops answer one cycle after start; the multiplier splits the
    // low-16 product into two partial products, a sum stage and an output stage.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            alu_done   <= 1'b0;
            alu_result <= '0;
`ifdef PROC_MUL_EN
            mul_pp_lo  <= '0;
            mul_pp_hi  <= '0;
            mul_sum    <= '0;
            mul_v1     <= 1'b0;
            mul_v2     <= 1'b0;
`endif
        end else begin
            alu_done <= 1'b0;
`ifdef PROC_MUL_EN
            mul_v1   <= 1'b0;
            mul_v2   <= mul_v1;
            mul_sum  <= mul_pp_lo + {mul_pp_hi, 8'h00};
            if (mul_v2) begin
                alu_result <= mul_sum;
                alu_done   <= 1'b1;
            end
`endif
            if (alu_start) begin
                case (alu_op)
                    OP_ADD: begin
                        alu_result <= alu_a + alu_b;
                        alu_done   <= 1'b1;
                    end
                    OP_AND: begin
                        alu_result <= alu_a & alu_b;
                        alu_done   <= 1'b1;
                    end
                    OP_XOR: begin
                        alu_result <= alu_a ^ alu_b;
                        alu_done   <= 1'b1;
                    end
`ifdef PROC_MUL_EN
                    OP_MUL: begin
                        mul_pp_lo <= alu_a * {8'h00, alu_b[7:0]};
                        mul_pp_hi <= alu_a[7:0] * alu_b[15:8];
                        mul_v1    <= 1'b1;
                    end
`endif
                    default: begin
                        alu_done <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_proc_core.sv
// Directed bench for proc_core: behavioural memory responder plus one task per scenario.
module tb_proc_core;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic halted;
    logic error;

    proc_core_if #(.ADDR_W(16)) bus ();

    proc_core #(.ADDR_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mem     (bus),
        .halted  (halted),
        .error   (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [0:255];
    logic [15:0] wait_addr = 16'hFFFF;
    int          wait_n = 0;
    bit          stray_en = 1'b0;
    bit          unstable = 1'b0;
    bit          both_req = 1'b0;
    bit          preq_bad = 1'b0;
    int          req_cycles = 0;
    int          wait_req_cycles = 0;
    logic [15:0] wlog_addr[$];
    logic [15:0] wlog_data[$];

    // Memory port model: answers after wait_n cycles for wait_addr, else at once.
    initial begin
        int          waitc;
        bit          tracking;
        logic [15:0] cap_addr;
        logic [15:0] cap_wd;
        logic        cap_rd;
        waitc = 0;
        tracking = 1'b0;
        cap_addr = '0;
        cap_wd = '0;
        cap_rd = 1'b0;
        bus.processor_resp = 1'b0;
        bus.mem_read_data = '0;
        forever begin
            @(negedge clk);
            bus.processor_resp = 1'b0;
            if (reset_n) begin
                tracking = 1'b0;
                continue;
            end
            if (bus.mem_read_req && bus.mem_write_req) both_req = 1'b1;
            if (bus.processor_req !== (bus.mem_read_req | bus.mem_write_req)) preq_bad = 1'b1;
            if (bus.mem_read_req || bus.mem_write_req) begin
                req_cycles++;
                if (bus.mem_addr == wait_addr && bus.mem_read_req) wait_req_cycles++;
                if (!tracking) begin
                    tracking = 1'b1;
                    waitc = 0;
                    cap_addr = bus.mem_addr;
                    cap_wd = bus.mem_write_data;
                    cap_rd = bus.mem_read_req;
                end else if (bus.mem_addr !== cap_addr || bus.mem_read_req !== cap_rd ||
                             (!cap_rd && bus.mem_write_data !== cap_wd)) begin
                    unstable = 1'b1;
                end
                if (waitc >= ((bus.mem_addr == wait_addr && bus.mem_read_req) ? wait_n : 0)) begin
                    bus.processor_resp = 1'b1;
                    if (bus.mem_read_req) begin
                        bus.mem_read_data = mem[bus.mem_addr[7:0]];
                    end else begin
                        mem[bus.mem_addr[7:0]] = bus.mem_write_data;
                        wlog_addr.push_back(bus.mem_addr);
                        wlog_data.push_back(bus.mem_write_data);
                    end
                    tracking = 1'b0;
                end else begin
                    waitc++;
                end
            end else begin
                tracking = 1'b0;
                if (stray_en) bus.processor_resp = 1'b1;
            end
        end
    end

    task automatic start_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        wait_addr = 16'hFFFF;
        wait_n = 0;
        stray_en = 1'b0;
        unstable = 1'b0;
        wait_req_cycles = 0;
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
    endtask

    task automatic wait_halt(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        start_reset();
        wait_addr = 16'h0000;
        wait_n = 50;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.mem_read_req, bus.mem_write_req, bus.processor_req, halted, error,
                 bus.mem_addr, bus.mem_write_data} !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs: got rd=%b wr=%b req=%b halt=%b err=%b addr=%h wd=%h expected all 0",
                         bus.mem_read_req, bus.mem_write_req, bus.processor_req, halted, error,
                         bus.mem_addr, bus.mem_write_data);
            end
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.mem_read_req !== 1'b1 || bus.processor_req !== 1'b1) begin
            n_errors++;
            $display("FAIL first_fetch_req: got rd=%b req=%b expected 1 1", bus.mem_read_req, bus.processor_req);
        end
        n_checks++;
        if (bus.mem_addr !== 16'h0000) begin
            n_errors++;
            $display("FAIL first_fetch_addr: got %h expected 0000", bus.mem_addr);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_read_req !== 1'b0 || bus.processor_req !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset_drop: got rd=%b req=%b expected 0 0", bus.mem_read_req, bus.processor_req);
        end
    endtask

    task automatic load_alu_prog();
        mem[0] = 16'h1405;  // LDI r1,5
        mem[1] = 16'h1807;  // LDI r2,7
        mem[2] = 16'h2600;  // ADD r1,r2
        mem[3] = 16'h7480;  // STORE r1,0x80
        mem[4] = 16'h8000;  // HALT
    endtask

    task automatic check_single_store(input string name, input logic [15:0] exp_addr,
                                      input logic [15:0] exp_data);
        n_checks++;
        if (wlog_addr.size() != 1) begin
            n_errors++;
            $display("FAIL %s_store_count: got %0d expected 1", name, wlog_addr.size());
        end else begin
            n_checks++;
            if (wlog_addr[0] !== exp_addr || wlog_data[0] !== exp_data) begin
                n_errors++;
                $display("FAIL %s_store: got addr=%h data=%h expected addr=%h data=%h",
                         name, wlog_addr[0], wlog_data[0], exp_addr, exp_data);
            end
        end
    endtask

    task automatic test_alu_program();
        bit ok;
        int snap;
        start_reset();
        load_alu_prog();
        release_reset();
        wait_halt(200, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL alu_halt: got halted=0 after 200 cycles expected 1");
        end
        check_single_store("alu", 16'h0080, 16'h000C);
        n_checks++;
        if (error !== 1'b0) begin
            n_errors++;
            $display("FAIL alu_error: got %b expected 0", error);
        end
        snap = req_cycles;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (req_cycles != snap || halted !== 1'b1) begin
            n_errors++;
            $display("FAIL alu_quiet_after_halt: got req_cycles=%0d halted=%b expected %0d 1",
                     req_cycles, halted, snap);
        end
    endtask

    task automatic test_load_wrap();
        bit ok;
        start_reset();
        mem[0] = 16'h6040;  // LOAD r0,0x40
        mem[1] = 16'h1401;  // LDI r1,1
        mem[2] = 16'h2100;  // ADD r0,r1
        mem[3] = 16'h7041;  // STORE r0,0x41
        mem[4] = 16'h8000;  // HALT
        mem[8'h40] = 16'hFFFF;
        wait_addr = 16'h0040;
        wait_n = 5;
        release_reset();
        wait_halt(200, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL load_halt: got halted=0 after 200 cycles expected 1");
        end
        n_checks++;
        if (wait_req_cycles != 6) begin
            n_errors++;
            $display("FAIL load_wait_cycles: got %0d expected 6", wait_req_cycles);
        end
        n_checks++;
        if (unstable !== 1'b0) begin
            n_errors++;
            $display("FAIL load_req_stable: got unstable=%b expected 0", unstable);
        end
        check_single_store("wrap", 16'h0041, 16'h0000);
    endtask

    task automatic test_mul();
        bit ok;
        start_reset();
        mem[0] = 16'h6450;  // LOAD r1,0x50
        mem[1] = 16'h6850;  // LOAD r2,0x50
        mem[2] = 16'h5600;  // MUL r1,r2
        mem[3] = 16'h7490;  // STORE r1,0x90
        mem[4] = 16'h8000;  // HALT
        mem[8'h50] = 16'd300;
        release_reset();
        wait_halt(200, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL mul_halt: got halted=0 after 200 cycles expected 1");
        end
`ifdef PROC_MUL_EN
        check_single_store("mul", 16'h0090, 16'h5F90);
        n_checks++;
        if (error !== 1'b0) begin
            n_errors++;
            $display("FAIL mul_error: got %b expected 0", error);
        end
`else
        n_checks++;
        if (error !== 1'b1) begin
            n_errors++;
            $display("FAIL mul_disabled_error: got %b expected 1", error);
        end
        n_checks++;
        if (wlog_addr.size() != 0) begin
            n_errors++;
            $display("FAIL mul_disabled_no_store: got %0d stores expected 0", wlog_addr.size());
        end
`endif
    endtask

    task automatic test_illegal();
        int snap;
        start_reset();
        mem[0] = 16'hF000;
        release_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.mem_read_req !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_fetch: got rd=%b expected 1", bus.mem_read_req);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.mem_read_req !== 1'b0 || halted !== 1'b0 || error !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_decode_cycle: got rd=%b halt=%b err=%b expected 0 0 0",
                     bus.mem_read_req, halted, error);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (error !== 1'b1 || halted !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_flags: got err=%b halt=%b expected 1 1", error, halted);
        end
        snap = req_cycles;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (req_cycles != snap || error !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_quiet: got req_cycles=%0d err=%b expected %0d 1", req_cycles, error, snap);
        end
    endtask

    task automatic test_stray_ack();
        bit ok;
        start_reset();
        load_alu_prog();
        stray_en = 1'b1;
        release_reset();
        wait_halt(200, ok);
        n_checks++;
        if (!ok || error !== 1'b0) begin
            n_errors++;
            $display("FAIL stray_halt: got halted=%b err=%b expected 1 0", ok, error);
        end
        check_single_store("stray", 16'h0080, 16'h000C);
    endtask

    task automatic test_protocol();
        n_checks++;
        if (both_req !== 1'b0) begin
            n_errors++;
            $display("FAIL one_req_at_a_time: got both=%b expected 0", both_req);
        end
        n_checks++;
        if (preq_bad !== 1'b0) begin
            n_errors++;
            $display("FAIL processor_req_or: got bad=%b expected 0", preq_bad);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_program();
        test_load_wrap();
        test_mul();
        test_illegal();
        test_stray_ack();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
